// File: rtl/disp_scan_ctrl.sv
// Four-digit multiplexed display scanner: SHOW/GAP phase FSM per digit, frame-wide input snapshot.
// Outputs come from registers only; en additionally gates the anode drive and the frame pulse.
module disp_scan_ctrl #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int GAP_CYCLES   = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] hexs,
  input  logic [3:0]  points,
  input  logic [3:0]  LEs,
  output logic [1:0]  scan,
  output logic [3:0]  AN,
  output logic [3:0]  digit,
  output logic        dp,
  output logic        frame_tick
);

  localparam int MAXC = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] SHOW_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic {SHOW = 1'b0, GAP = 1'b1} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_scan;
  logic [15:0]   r_hexs;
  logic [3:0]    r_points;
  logic [3:0]    r_les;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_advance;
  logic          w_wrap;
  logic [3:0]    w_an;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_advance   = 1'b0;
    if (en) begin
      case (r_state)
        SHOW: begin
          if (r_cnt == SHOW_LAST) begin
            w_cnt_nxt = '0;
            // Without a blanking gap the lit phase hands straight to the next digit.
            if (GAP_CYCLES == 0) begin
              w_advance = 1'b1;
            end else begin
              w_state_nxt = GAP;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        GAP: begin
          if (r_cnt == GAP_LAST) begin
            w_state_nxt = SHOW;
            w_cnt_nxt   = '0;
            w_advance   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = SHOW;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign w_wrap = w_advance && (r_scan == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= SHOW;
      r_cnt    <= '0;
      r_scan   <= 2'd0;
      r_hexs   <= hexs;
      r_points <= points;
      r_les    <= LEs;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_advance) begin
        r_scan <= r_scan + 2'd1;
      end
      // The snapshot only refreshes at frame boundaries so a frame never tears.
      if (w_wrap) begin
        r_hexs   <= hexs;
        r_points <= points;
        r_les    <= LEs;
      end
    end
  end

  always_comb begin
    w_an = 4'b1111;
    if ((r_state == SHOW) && en && !r_les[r_scan]) begin
      w_an[r_scan] = 1'b0;
    end
  end

  assign scan       = r_scan;
  assign AN         = w_an;
  assign digit      = r_hexs[{r_scan, 2'b00} +: 4];
  assign dp         = r_points[r_scan];
  assign frame_tick = w_wrap & ~rst;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: one instance with a blanking gap, one without, checked against a frame-position model.
module tb_disp_scan_ctrl;

  localparam int D = 8;
  localparam int GV [2] = '{2, 0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [15:0] hexs = 16'h0000;
  logic [3:0]  points = 4'h0;
  logic [3:0]  LEs = 4'h0;

  logic [1:0][1:0] scan_o;
  logic [1:0][3:0] an_o;
  logic [1:0][3:0] digit_o;
  logic [1:0]      dp_o;
  logic [1:0]      ft_o;

  int n_chk  = 0;
  int n_pass = 0;
  bit armed  = 1'b0;

  // model state per instance: position within the frame and the frame snapshot
  int          t    [2];
  logic [15:0] s_hex[2];
  logic [3:0]  s_pt [2];
  logic [3:0]  s_le [2];

  always #5 clk = ~clk;

  disp_scan_ctrl #(.DIGIT_CYCLES(D), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .en(en), .hexs(hexs), .points(points), .LEs(LEs),
    .scan(scan_o[0]), .AN(an_o[0]), .digit(digit_o[0]), .dp(dp_o[0]), .frame_tick(ft_o[0])
  );

  disp_scan_ctrl #(.DIGIT_CYCLES(D), .GAP_CYCLES(0)) dut_g0 (
    .clk(clk), .rst(rst), .en(en), .hexs(hexs), .points(points), .LEs(LEs),
    .scan(scan_o[1]), .AN(an_o[1]), .digit(digit_o[1]), .dp(dp_o[1]), .frame_tick(ft_o[1])
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
  endtask

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      int fl;
      fl = 4 * (D + GV[m]);
      if (rst) begin
        t[m] = 0;
        s_hex[m] = hexs; s_pt[m] = points; s_le[m] = LEs;
      end else if (en) begin
        if (t[m] == fl - 1) begin
          t[m] = 0;
          s_hex[m] = hexs; s_pt[m] = points; s_le[m] = LEs;
        end else begin
          t[m] = t[m] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int m = 0; m < 2; m++) begin
        int sl, slot, ph;
        logic [3:0] exp_an;
        logic [15:0] h;
        sl   = D + GV[m];
        slot = t[m] / sl;
        ph   = t[m] % sl;
        h    = s_hex[m] >> (4 * slot);
        exp_an = 4'b1111;
        if (ph < D && en && !s_le[m][slot]) exp_an = ~(4'b0001 << slot);
        chk($sformatf("m%0d scan", m), scan_o[m], slot);
        chk($sformatf("m%0d digit", m), digit_o[m], h[3:0]);
        chk($sformatf("m%0d dp", m), dp_o[m], s_pt[m][slot]);
        chk($sformatf("m%0d AN", m), an_o[m], exp_an);
        chk($sformatf("m%0d frame_tick", m), ft_o[m],
            (en && !rst && t[m] == 4 * sl - 1) ? 1 : 0);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [15:0] h, input logic [3:0] p, input logic [3:0] l);
    rst = 1'b1; en = 1'b1; hexs = h; points = p; LEs = l;
    next_cycle();
    rst = 1'b0;
    armed = 1'b1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    next_cycle();

    // basic scan, mid-frame input change must not tear
    do_reset(16'h1234, 4'b0001, 4'b0000);
    for (int k = 0; k < 41; k++) begin
      if (k == 15) hexs = 16'hABCD;
      settle();
      if (k == 0) begin
        chk("s1 c0 scan", scan_o[0], 0);
        chk("s1 c0 digit", digit_o[0], 4'h4);
        chk("s1 c0 dp", dp_o[0], 1);
        chk("s1 c0 AN", an_o[0], 4'b1110);
        chk("s1 c0 tick", ft_o[0], 0);
      end
      if (k == 8)  chk("s1 c8 AN", an_o[0], 4'b1111);
      if (k == 8)  chk("s1 g0 c8 AN", an_o[1], 4'b1101);
      if (k == 10) chk("s1 c10 digit", digit_o[0], 4'h3);
      if (k == 10) chk("s1 c10 AN", an_o[0], 4'b1101);
      if (k == 20) chk("s1 c20 digit", digit_o[0], 4'h2);
      if (k == 31) chk("s1 g0 c31 tick", ft_o[1], 1);
      if (k == 32) chk("s1 g0 c32 digit", digit_o[1], 4'hD);
      if (k == 38) chk("s1 c38 tick", ft_o[0], 0);
      if (k == 39) chk("s1 c39 tick", ft_o[0], 1);
      if (k == 39) chk("s1 c39 digit", digit_o[0], 4'h1);
      if (k == 40) begin
        chk("s1 c40 digit", digit_o[0], 4'hD);
        chk("s1 c40 AN", an_o[0], 4'b1110);
      end
      next_cycle();
    end

    // per-digit blanking
    do_reset(16'h1234, 4'b0000, 4'b0101);
    for (int k = 0; k < 40; k++) begin
      settle();
      if (k == 0)  chk("s2 c0 AN", an_o[0], 4'b1111);
      if (k == 10) chk("s2 c10 AN", an_o[0], 4'b1101);
      if (k == 20) chk("s2 c20 AN", an_o[0], 4'b1111);
      if (k == 20) chk("s2 c20 scan", scan_o[0], 2);
      if (k == 30) chk("s2 c30 AN", an_o[0], 4'b0111);
      next_cycle();
    end

    // enable pause inside digit 0
    do_reset(16'h1234, 4'b0000, 4'b0000);
    for (int k = 0; k < 46; k++) begin
      if (k == 5)  en = 1'b0;
      if (k == 10) en = 1'b1;
      settle();
      if (k == 5)  chk("s3 c5 AN", an_o[0], 4'b1111);
      if (k == 12) chk("s3 c12 AN", an_o[0], 4'b1110);
      if (k == 13) chk("s3 c13 AN", an_o[0], 4'b1111);
      if (k == 14) chk("s3 c14 scan", scan_o[0], 0);
      if (k == 15) chk("s3 c15 AN", an_o[0], 4'b1101);
      if (k == 44) chk("s3 c44 tick", ft_o[0], 1);
      next_cycle();
    end

    // reset mid-frame
    do_reset(16'h1234, 4'b0000, 4'b0000);
    for (int k = 0; k < 70; k++) begin
      if (k == 23) begin rst = 1'b1; hexs = 16'h5A5A; end
      if (k == 24) rst = 1'b0;
      settle();
      if (k == 24) begin
        chk("s4 c24 scan", scan_o[0], 0);
        chk("s4 c24 digit", digit_o[0], 4'hA);
        chk("s4 c24 AN", an_o[0], 4'b1110);
      end
      if (k == 39) chk("s4 c39 tick", ft_o[0], 0);
      if (k == 55) chk("s4 g0 c55 tick", ft_o[1], 1);
      if (k == 62) chk("s4 c62 tick", ft_o[0], 0);
      if (k == 63) chk("s4 c63 tick", ft_o[0], 1);
      next_cycle();
    end

    // churned inputs and sporadic enable drops
    do_reset(16'hC0DE, 4'b1010, 4'b0010);
    for (int k = 0; k < 200; k++) begin
      hexs   = 16'($urandom);
      points = 4'($urandom_range(0, 15));
      LEs    = 4'($urandom_range(0, 15));
      en     = ($urandom_range(0, 7) != 0);
      settle();
      next_cycle();
    end

    armed = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
